// File: rtl/mmu_dm_arbiter.sv
// Shares the single MMU data-memory port between the CPU MEM stage and a debug/loader master.
// Optional build macro MMU_ARB_PERF_EN adds read-only CPU-stall and dbg-grant performance counters.
module mmu_dm_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int STARVE_W   = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_signed,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [3:0]  dbg_be,
  input  logic        dbg_signed,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_di,
  output logic [3:0]  dm_be,
  output logic        dm_we,
  output logic        is_signed,
  input  logic [31:0] dm_do
`ifdef MMU_ARB_PERF_EN
  ,
  output logic [31:0] perf_cpu_stall,
  output logic [15:0] perf_dbg_gnt
`endif
);

  localparam logic [0:0] ARB_CPU = 1'b0;
  localparam logic [0:0] ARB_DBG = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [0:0]          state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic [1:0]          resp_owner, resp_owner_nxt;
  logic                dbg_denied;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (state == ARB_CPU) begin
      cpu_gnt = cpu_req;
      dbg_gnt = dbg_req & ~cpu_req;
    end else begin
      dbg_gnt = dbg_req;
    end
  end

  // Idle port drives all zeros so no BRAM bank is enabled.
  always_comb begin
    dm_addr   = '0;
    dm_di     = '0;
    dm_be     = '0;
    dm_we     = 1'b0;
    is_signed = 1'b0;
    if (cpu_gnt) begin
      dm_addr   = cpu_addr;
      dm_di     = cpu_wdata;
      dm_be     = cpu_be;
      dm_we     = cpu_we;
      is_signed = cpu_signed;
    end else if (dbg_gnt) begin
      dm_addr   = dbg_addr;
      dm_di     = dbg_wdata;
      dm_be     = dbg_be;
      dm_we     = dbg_we;
      is_signed = dbg_signed;
    end
  end

  assign dbg_denied = dbg_req & ~dbg_gnt;

  always_comb begin
    starve_nxt = '0;
    if (dbg_denied) begin
      starve_nxt = (starve_cnt == '1) ? starve_cnt : starve_cnt + STARVE_W'(1);
    end

    // A locked dbg grant or a starvation limit hit reserves the port for dbg next cycle.
    state_nxt = ARB_CPU;
    if (dbg_gnt && dbg_lock) begin
      state_nxt = ARB_DBG;
    end else if (dbg_denied && (starve_nxt == STARVE_LIM)) begin
      state_nxt = ARB_DBG;
    end

    resp_owner_nxt = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      resp_owner_nxt = OWN_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      resp_owner_nxt = OWN_DBG;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= ARB_CPU;
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      resp_owner <= resp_owner_nxt;
    end
  end

  // Read data is routed to whoever owned last cycle's read; the other side sees zeros.
  assign cpu_rvalid = (resp_owner == OWN_CPU);
  assign dbg_rvalid = (resp_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? dm_do : '0;
  assign dbg_rdata  = dbg_rvalid ? dm_do : '0;

`ifdef MMU_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      perf_cpu_stall <= '0;
      perf_dbg_gnt   <= '0;
    end else begin
      if (cpu_req && !cpu_gnt) perf_cpu_stall <= perf_cpu_stall + 32'd1;
      if (dbg_gnt)             perf_dbg_gnt   <= perf_dbg_gnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mmu_dm_arbiter.md
Name: mmu_dm_arbiter

Overview:
Shares the single MMU data-memory port (dm_addr/dm_di/dm_be/dm_we/is_signed -> dm_do, one-clock read latency) between the CPU load/store stage and a debug/loader master (UART bootloader, JTAG-style poke/peek).
- CPU has fixed priority.
- The debug master has starvation protection and an optional lock for multi-beat transfers.
- Read data is routed back to the owner of the access one cycle after grant.
- Sits between the pipeline MEM stage, the debug master, and the mmu instance.

Parameters:
STARVE_MAX, 8, consecutive denied dbg cycles before dbg is forced a grant (1..2^STARVE_W-1)
STARVE_W, 4, width of the starvation counter

Ports:
clk  input  1  clock
resetb  input  1  reset, asynchronous, active-low
cpu_req  input  1  CPU access request, held until granted
cpu_we  input  1  CPU write
cpu_addr  input  32  CPU byte address
cpu_wdata  input  32  CPU store data, right-aligned
cpu_be  input  4  CPU byte enables, non-encoded
cpu_signed  input  1  CPU load sign-extend
cpu_gnt  output  1  CPU access accepted this cycle
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  32  CPU read data
dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0], dbg_be[3:0], dbg_signed  input  debug master request set, same meaning as the CPU set
dbg_lock  input  1  dbg holds the port while asserted after its first grant
dbg_gnt  output  1  dbg access accepted this cycle
dbg_rvalid  output  1  dbg read data valid
dbg_rdata  output  32  dbg read data
dm_addr  output  32  to MMU
dm_di  output  32  to MMU
dm_be  output  4  to MMU; 4'b0000 when idle
dm_we  output  1  to MMU
is_signed  output  1  to MMU
dm_do  input  32  from MMU, valid one cycle after access

Behaviour:
- Grant logic is combinational (same-cycle grant); the MMU captures its inputs at the next clk edge.
- At most one of cpu_gnt/dbg_gnt is high in any cycle.
- The granted requester's set is muxed onto dm_*.
- With no grant: dm_be=0, dm_we=0, dm_addr=0, dm_di=0, is_signed=0, so no BRAM bank is enabled.
- Arbiter state machine:
  - ARB_CPU: CPU wins if cpu_req. dbg wins if dbg_req and !cpu_req.
  - Starvation: when dbg_req is denied by cpu_req, starve_cnt increments, saturating.
  - When starve_cnt reaches STARVE_MAX at a clock edge with dbg_req still high, the next state is ARB_DBG.
  - ARB_DBG: dbg granted unconditionally if dbg_req; cpu_gnt=0; starve_cnt cleared on exit.
  - Exit to ARB_CPU after one dbg grant, unless dbg_lock=1. With dbg_lock=1, stay in ARB_DBG (CPU stalled) until a cycle with dbg_lock=0 or dbg_req=0.
  - In ARB_CPU, a dbg grant with dbg_lock=1 also enters ARB_DBG.
  - starve_cnt clears on any dbg grant or when dbg_req=0.
- Response tracking:
  - Register resp_owner (NONE/CPU/DBG) is set at each edge from a granted read (we=0). A granted write or no grant sets it to NONE.
  - Next cycle: owner's rvalid=1, owner's rdata=dm_do. The other rdata=0 and rvalid=0.
  - Writes produce no rvalid.
- Back-to-back: a grant in cycle N and another in N+1 are legal. rvalid for N appears in N+1 regardless of the N+1 grant.
- Simultaneous cpu_req and dbg_req in ARB_CPU with starve_cnt<STARVE_MAX: CPU wins and starve_cnt increments.
- STARVE_MAX edge case: forced state lasts exactly one dbg grant when dbg_lock=0.
- Reset, async, mid-operation:
  - State -> ARB_CPU, starve_cnt=0, resp_owner=NONE.
  - cpu_rvalid=dbg_rvalid=0 and both rdata=0 immediately.
  - Any in-flight read response is dropped; the requester re-issues.
- Requests are not required to be held stable while ungranted beyond holding req; the mux samples current inputs.

Optional Feature:
MMU_ARB_PERF_EN
- Defined:
  - Adds outputs perf_cpu_stall[31:0], counting cycles with cpu_req=1 and cpu_gnt=0.
  - Adds output perf_dbg_gnt[15:0], counting dbg grants.
  - Both counters wrap at their width, clear on reset, and are read-only.
- Undefined: ports and counters absent; arbitration behaviour is identical either way.

Test Plan:
- Reset, then idle -> dm_be=0, dm_we=0, both gnt=0, both rvalid=0.
- CPU read addr 0x10000004 be=1111, MMU returns 0xDEADBEEF -> cpu_gnt=1 in cycle N; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1; dbg_rvalid=0.
- cpu_req held high continuously with dbg_req high, STARVE_MAX=8 -> dbg denied 8 cycles, then dbg_gnt=1 for exactly one cycle with cpu_gnt=0, then CPU resumes.
- dbg write then dbg_lock=1 for 4 writes to 0x10000000..0x1000000C with cpu_req=1 -> 4 consecutive dbg_gnt, cpu_gnt=0 throughout, CPU granted the cycle after lock drops.
- Alternating CPU read / dbg read back-to-back -> each rvalid lands on the correct owner one cycle later with the matching dm_do, no crossover.
- resetb pulsed low in the cycle after a dbg read grant -> dbg_rvalid stays 0; after release state=ARB_CPU, starve_cnt=0; with MMU_ARB_PERF_EN, perf counters read 0.
